// File: rtl/wash_pkg.sv
// rtl/wash_pkg.sv - shared codes, data-word layout and encode helpers for the wash program setter
// Contents:
//   top-state codes shutDownST..finishST, mode codes set_WRD_ST..set_USE_ST,
//   setter FSM state type, data-word field offsets, mode->group enable mask,
//   data-word encoder and field-sum helper.
package wash_pkg;

    // Top FSM state codes (driven by the top controller on the state port)
    localparam logic [2:0] shutDownST = 3'd0;
    localparam logic [2:0] beginST    = 3'd1;
    localparam logic [2:0] setST      = 3'd2;
    localparam logic [2:0] runST      = 3'd3;
    localparam logic [2:0] errorST    = 3'd4;
    localparam logic [2:0] pauseST    = 3'd5;
    localparam logic [2:0] finishST   = 3'd6;

    // Wash-program mode codes
    localparam logic [2:0] set_WRD_ST = 3'd0;
    localparam logic [2:0] set_W_ST   = 3'd1;
    localparam logic [2:0] set_WR_ST  = 3'd2;
    localparam logic [2:0] set_R_ST   = 3'd3;
    localparam logic [2:0] set_RD_ST  = 3'd4;
    localparam logic [2:0] set_D_ST   = 3'd5;
    localparam logic [2:0] set_USE_ST = 3'd6;

    // Data word: {wIn3,wW4,rOut3,rSpin3,rIn3,rR4,dOut3,dSpin3}
    localparam int DATA_W     = 26;
    localparam int W_IN_LSB   = 23;
    localparam int W_W_LSB    = 19;
    localparam int R_OUT_LSB  = 16;
    localparam int R_SPIN_LSB = 13;
    localparam int R_IN_LSB   = 10;
    localparam int R_R_LSB    = 6;
    localparam int D_OUT_LSB  = 3;
    localparam int D_SPIN_LSB = 0;

    typedef enum logic [1:0] {
        SET_IDLE = 2'd0,
        SET_EDIT = 2'd1,
        SET_LOCK = 2'd2
    } set_fsm_e;

    typedef struct packed {
        logic w;
        logic r;
        logic d;
    } grp_en_t;

    // Which of the wash / rinse / dry groups a mode runs
    function automatic grp_en_t mode_groups(input logic [2:0] mode);
        grp_en_t g;
        case (mode)
            set_WRD_ST, set_USE_ST: g = '{w: 1'b1, r: 1'b1, d: 1'b1};
            set_W_ST:               g = '{w: 1'b1, r: 1'b0, d: 1'b0};
            set_WR_ST:              g = '{w: 1'b1, r: 1'b1, d: 1'b0};
            set_R_ST:               g = '{w: 1'b0, r: 1'b1, d: 1'b0};
            set_RD_ST:              g = '{w: 1'b0, r: 1'b1, d: 1'b1};
            set_D_ST:               g = '{w: 1'b0, r: 1'b0, d: 1'b1};
            default:                g = '{w: 1'b0, r: 1'b0, d: 1'b0};
        endcase
        return g;
    endfunction

    // Builds the packed data word; disabled groups are all-zero, USE halves wash/rinse
    function automatic logic [DATA_W-1:0] encode_data(
        input logic [2:0] mode,
        input logic [2:0] lvl,
        input logic [3:0] wash_t,
        input logic [3:0] rinse_t,
        input logic [2:0] spin_t
    );
        grp_en_t    g;
        logic [3:0] wash_v;
        logic [3:0] rinse_v;
        logic [2:0] lw, lr, ld, sr, sd;
        logic [3:0] ww, rr;
        g       = mode_groups(mode);
        wash_v  = (mode == set_USE_ST) ? (wash_t >> 1)  : wash_t;
        rinse_v = (mode == set_USE_ST) ? (rinse_t >> 1) : rinse_t;
        lw = g.w ? lvl     : 3'd0;
        ww = g.w ? wash_v  : 4'd0;
        lr = g.r ? lvl     : 3'd0;
        sr = g.r ? spin_t  : 3'd0;
        rr = g.r ? rinse_v : 4'd0;
        ld = g.d ? lvl     : 3'd0;
        sd = g.d ? spin_t  : 3'd0;
        return {lw, ww, lr, sr, lr, rr, ld, sd};
    endfunction

    // Sum of all eight fields; worst case 7+15+7+7+7+15+7+7 = 72 fits in 8 bits
    function automatic logic [7:0] data_total(input logic [DATA_W-1:0] d);
        return 8'(d[W_IN_LSB   +: 3]) + 8'(d[W_W_LSB    +: 4])
             + 8'(d[R_OUT_LSB  +: 3]) + 8'(d[R_SPIN_LSB +: 3])
             + 8'(d[R_IN_LSB   +: 3]) + 8'(d[R_R_LSB    +: 4])
             + 8'(d[D_OUT_LSB  +: 3]) + 8'(d[D_SPIN_LSB +: 3]);
    endfunction

endpackage

// File: rtl/wash_key_edge.sv
// rtl/wash_key_edge.sv - key synchroniser, optional debounce filter and rising-edge detector
// Optional feature macro: WASH_DEBOUNCE_EN (debounce filter of DEB_CYCLES stable cycles)
// Ports:
//   cp     in  clock
//   rst_n  in  async active-low reset
//   key    in  raw asynchronous key level
//   press  out one-cycle pulse on filtered rising edge
module wash_key_edge #(
    parameter int DEB_CYCLES = 1000
) (
    input  logic cp,
    input  logic rst_n,
    input  logic key,
    output logic press
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;
    logic filt;

    always_ff @(posedge cp or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= key;
            sync2_q <= sync1_q;
        end
    end

`ifdef WASH_DEBOUNCE_EN
    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic [CW-1:0] cnt_q;
    logic          filt_q;

    // Counter tracks how long the synced key has disagreed with the filtered
    // level; any return to agreement restarts the window.
    always_ff @(posedge cp or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            filt_q <= 1'b0;
        end else if (sync2_q == filt_q) begin
            cnt_q  <= '0;
        end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
            cnt_q  <= '0;
            filt_q <= sync2_q;
        end else begin
            cnt_q  <= cnt_q + CW'(1);
        end
    end

    assign filt = filt_q;
`else
    logic [31:0] unused_deb_cycles;
    assign unused_deb_cycles = 32'(DEB_CYCLES);
    assign filt = sync2_q;
`endif

    // Reset to 0 so a key held through reset still looks like a fresh press
    always_ff @(posedge cp or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= filt;
        end
    end

    assign press = filt & ~prev_q;

endmodule

// File: rtl/wash_program_setter.sv
// rtl/wash_program_setter.sv - front-panel key handling and wash-program word writer
// Optional feature macro: WASH_DEBOUNCE_EN (key debounce, see wash_key_edge)
// Ports:
//   cp          in   clock
//   rst_n       in   async active-low reset
//   state       in   [2:0] top FSM state; editing happens while state == setST
//   key_mode    in   raw key, cycles program mode
//   key_level   in   raw key, cycles water level
//   key_ok      in   raw key, confirms program
//   setData     out  [2:0] current mode
//   data        out  [25:0] packed phase durations for the time controller
//   level       out  [2:0] current water level
//   total_time  out  [7:0] sum of all data fields
//   cfg_valid   out  one-cycle pulse on confirm
module wash_program_setter
    import wash_pkg::*;
#(
    parameter int WASH_T     = 9,
    parameter int RINSE_T    = 6,
    parameter int SPIN_T     = 3,
    parameter int LEVEL_MAX  = 5,
    parameter int LEVEL_RST  = 3,
    parameter int DEB_CYCLES = 1000
) (
    input  logic        cp,
    input  logic        rst_n,
    input  logic [2:0]  state,
    input  logic        key_mode,
    input  logic        key_level,
    input  logic        key_ok,
    output logic [2:0]  setData,
    output logic [25:0] data,
    output logic [2:0]  level,
    output logic [7:0]  total_time,
    output logic        cfg_valid
);

    localparam logic [3:0] WASH_V      = 4'(WASH_T);
    localparam logic [3:0] RINSE_V     = 4'(RINSE_T);
    localparam logic [2:0] SPIN_V      = 3'(SPIN_T);
    localparam logic [2:0] LEVEL_MAX_V = 3'(LEVEL_MAX);
    localparam logic [2:0] LEVEL_RST_V = 3'(LEVEL_RST);
    localparam logic [DATA_W-1:0] DATA_RST =
        encode_data(set_WRD_ST, LEVEL_RST_V, WASH_V, RINSE_V, SPIN_V);
    localparam logic [7:0] TOTAL_RST = data_total(DATA_RST);

    logic mode_press;
    logic level_press;
    logic ok_press;

    wash_key_edge #(.DEB_CYCLES(DEB_CYCLES)) u_key_mode (
        .cp    (cp),
        .rst_n (rst_n),
        .key   (key_mode),
        .press (mode_press)
    );

    wash_key_edge #(.DEB_CYCLES(DEB_CYCLES)) u_key_level (
        .cp    (cp),
        .rst_n (rst_n),
        .key   (key_level),
        .press (level_press)
    );

    wash_key_edge #(.DEB_CYCLES(DEB_CYCLES)) u_key_ok (
        .cp    (cp),
        .rst_n (rst_n),
        .key   (key_ok),
        .press (ok_press)
    );

    set_fsm_e          fsm_q;
    logic [2:0]        mode_q;
    logic [2:0]        level_q;
    logic              cfg_valid_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;
    logic [7:0]        total_q;
    logic [7:0]        total_d;

    always_ff @(posedge cp or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q       <= SET_IDLE;
            mode_q      <= set_WRD_ST;
            level_q     <= LEVEL_RST_V;
            cfg_valid_q <= 1'b0;
        end else begin
            cfg_valid_q <= 1'b0;
            if (state == shutDownST) begin
                fsm_q <= SET_IDLE;
            end else begin
                case (fsm_q)
                    SET_IDLE: begin
                        if (state == setST) begin
                            fsm_q <= SET_EDIT;
                        end
                    end
                    SET_EDIT: begin
                        // Confirm takes priority and swallows same-cycle edits
                        if (ok_press) begin
                            cfg_valid_q <= 1'b1;
                            fsm_q       <= SET_LOCK;
                        end else begin
                            if (mode_press) begin
                                mode_q <= (mode_q == set_USE_ST) ? set_WRD_ST : mode_q + 3'd1;
                            end
                            if (level_press) begin
                                level_q <= (level_q >= LEVEL_MAX_V) ? 3'd1 : level_q + 3'd1;
                            end
                        end
                    end
                    SET_LOCK: begin
                        if (state != setST) begin
                            fsm_q <= SET_IDLE;
                        end
                    end
                    default: begin
                        fsm_q <= SET_IDLE;
                    end
                endcase
            end
        end
    end

    // Encoder follows mode/level by one cycle; data and total update together
    always_comb begin
        data_d  = encode_data(mode_q, level_q, WASH_V, RINSE_V, SPIN_V);
        total_d = data_total(data_d);
    end

    always_ff @(posedge cp or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= DATA_RST;
            total_q <= TOTAL_RST;
        end else begin
            data_q  <= data_d;
            total_q <= total_d;
        end
    end

    assign setData    = mode_q;
    assign level      = level_q;
    assign data       = data_q;
    assign total_time = total_q;
    assign cfg_valid  = cfg_valid_q;

endmodule

// File: tb/tb_wash_program_setter.sv
// tb/tb_wash_program_setter.sv - directed self-checking bench for wash_program_setter
module tb_wash_program_setter;

`ifdef WASH_DEBOUNCE_EN
    localparam int HOLD   = 12;
    localparam int SETTLE = 16;
`else
    localparam int HOLD   = 2;
    localparam int SETTLE = 6;
`endif

    logic        cp = 1'b0;
    logic        rst_n;
    logic [2:0]  state;
    logic        key_mode;
    logic        key_level;
    logic        key_ok;
    logic [2:0]  setData;
    logic [25:0] data;
    logic [2:0]  level;
    logic [7:0]  total_time;
    logic        cfg_valid;

    int errors = 0;
    int checks = 0;

    always #5 cp = ~cp;

    wash_program_setter #(.DEB_CYCLES(8)) u_dut (
        .cp         (cp),
        .rst_n      (rst_n),
        .state      (state),
        .key_mode   (key_mode),
        .key_level  (key_level),
        .key_ok     (key_ok),
        .setData    (setData),
        .data       (data),
        .level      (level),
        .total_time (total_time),
        .cfg_valid  (cfg_valid)
    );

    task automatic cyc(input int n);
        repeat (n) @(posedge cp);
        #1;
    endtask

    // Drive a key combination for HOLD cycles, release, settle; count cfg_valid cycles
    task automatic pulse(input logic m, input logic l, input logic o, output int vcnt);
        vcnt = 0;
        key_mode = m; key_level = l; key_ok = o;
        for (int i = 0; i < HOLD; i++) begin
            cyc(1);
            if (cfg_valid === 1'b1) vcnt++;
        end
        key_mode = 1'b0; key_level = 1'b0; key_ok = 1'b0;
        for (int i = 0; i < SETTLE; i++) begin
            cyc(1);
            if (cfg_valid === 1'b1) vcnt++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; state = 3'd0;
        key_mode = 1'b0; key_level = 1'b0; key_ok = 1'b0;
        cyc(2);
        checks++; if (setData !== 3'd0) begin errors++; $display("FAIL reset_setData got=%0d exp=0", setData); end
        checks++; if (level !== 3'd3) begin errors++; $display("FAIL reset_level got=%0d exp=3", level); end
        checks++; if (data !== 26'h1CB6D9B) begin errors++; $display("FAIL reset_data got=%h exp=1cb6d9b", data); end
        checks++; if (total_time !== 8'd33) begin errors++; $display("FAIL reset_total got=%0d exp=33", total_time); end
        checks++; if (cfg_valid !== 1'b0) begin errors++; $display("FAIL reset_cfg_valid got=%b exp=0", cfg_valid); end
        rst_n = 1'b1; state = 3'd2;
        cyc(4);
        checks++; if (setData !== 3'd0 || level !== 3'd3 || data !== 26'h1CB6D9B || total_time !== 8'd33 || cfg_valid !== 1'b0) begin
            errors++;
            $display("FAIL set_idle_nokeys got=%0d/%0d/%h/%0d/%b exp=0/3/1cb6d9b/33/0", setData, level, data, total_time, cfg_valid);
        end
    endtask

    task automatic test_mode();
        logic [2:0]  exp_m[7] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd0};
        logic [25:0] exp_d[7] = '{26'h1C80000, 26'h1CB6D80, 26'h0036D80, 26'h0036D9B,
                                  26'h000001B, 26'h1A36CDB, 26'h1CB6D9B};
        logic [7:0]  exp_t[7] = '{8'd12, 8'd27, 8'd15, 8'd21, 8'd6, 8'd25, 8'd33};
        int v;
        for (int i = 0; i < 7; i++) begin
            pulse(1'b1, 1'b0, 1'b0, v);
            checks++; if (setData !== exp_m[i]) begin errors++; $display("FAIL mode_setData[%0d] got=%0d exp=%0d", i, setData, exp_m[i]); end
            checks++; if (data !== exp_d[i]) begin errors++; $display("FAIL mode_data[%0d] got=%h exp=%h", i, data, exp_d[i]); end
            checks++; if (total_time !== exp_t[i]) begin errors++; $display("FAIL mode_total[%0d] got=%0d exp=%0d", i, total_time, exp_t[i]); end
        end
    endtask

    task automatic test_level();
        logic [2:0]  exp_l[3] = '{3'd4, 3'd5, 3'd1};
        logic [25:0] exp_d[3] = '{26'h24C71A3, 26'h2CD75AB, 26'h0C9658B};
        logic [7:0]  exp_t[3] = '{8'd37, 8'd41, 8'd25};
        int v;
        for (int i = 0; i < 3; i++) begin
            pulse(1'b0, 1'b1, 1'b0, v);
            checks++; if (level !== exp_l[i]) begin errors++; $display("FAIL level_val[%0d] got=%0d exp=%0d", i, level, exp_l[i]); end
            checks++; if (data !== exp_d[i]) begin errors++; $display("FAIL level_data[%0d] got=%h exp=%h", i, data, exp_d[i]); end
            checks++; if (total_time !== exp_t[i]) begin errors++; $display("FAIL level_total[%0d] got=%0d exp=%0d", i, total_time, exp_t[i]); end
        end
        pulse(1'b1, 1'b1, 1'b0, v);
        checks++; if (setData !== 3'd1 || level !== 3'd2) begin errors++; $display("FAIL mode_level_both got=%0d/%0d exp=1/2", setData, level); end
        checks++; if (data !== 26'h1480000 || total_time !== 8'd11) begin errors++; $display("FAIL mode_level_data got=%h/%0d exp=1480000/11", data, total_time); end
    endtask

    task automatic test_ok();
        int v;
        pulse(1'b1, 1'b0, 1'b1, v);
        checks++; if (v !== 1) begin errors++; $display("FAIL ok_cfg_pulses got=%0d exp=1", v); end
        checks++; if (setData !== 3'd1) begin errors++; $display("FAIL ok_wins_setData got=%0d exp=1", setData); end
        pulse(1'b1, 1'b1, 1'b0, v);
        checks++; if (setData !== 3'd1 || level !== 3'd2 || v !== 0) begin errors++; $display("FAIL lock_ignore got=%0d/%0d/%0d exp=1/2/0", setData, level, v); end
        state = 3'd3; cyc(2);
        pulse(1'b1, 1'b1, 1'b1, v);
        checks++; if (setData !== 3'd1 || level !== 3'd2 || data !== 26'h1480000 || v !== 0) begin
            errors++; $display("FAIL run_ignore got=%0d/%0d/%h/%0d exp=1/2/1480000/0", setData, level, data, v);
        end
        state = 3'd2; cyc(2);
        pulse(1'b1, 1'b0, 1'b0, v);
        checks++; if (setData !== 3'd2) begin errors++; $display("FAIL reedit_setData got=%0d exp=2", setData); end
        checks++; if (data !== 26'h14A6980 || total_time !== 8'd24) begin errors++; $display("FAIL reedit_data got=%h/%0d exp=14a6980/24", data, total_time); end
    endtask

    task automatic test_back_to_idle();
        int v;
        state = 3'd0; cyc(2);
        state = 3'd1; cyc(2);
        pulse(1'b1, 1'b1, 1'b1, v);
        checks++; if (setData !== 3'd2 || level !== 3'd2 || v !== 0) begin errors++; $display("FAIL begin_ignore got=%0d/%0d/%0d exp=2/2/0", setData, level, v); end
        state = 3'd2; cyc(2);
        pulse(1'b0, 1'b0, 1'b1, v);
        checks++; if (v !== 1) begin errors++; $display("FAIL ok_only_pulses got=%0d exp=1", v); end
        state = 3'd0; cyc(2);
        state = 3'd2; cyc(2);
        pulse(1'b0, 1'b1, 1'b0, v);
        checks++; if (level !== 3'd3 || setData !== 3'd2) begin errors++; $display("FAIL lock_to_idle_edit got=%0d/%0d exp=3/2", level, setData); end
    endtask

    task automatic test_reset_mid_edit();
        key_level = 1'b1;
        cyc(1);
        rst_n = 1'b0;
        #1;
        checks++; if (setData !== 3'd0 || level !== 3'd3 || data !== 26'h1CB6D9B || total_time !== 8'd33 || cfg_valid !== 1'b0) begin
            errors++; $display("FAIL async_reset got=%0d/%0d/%h/%0d/%b exp=0/3/1cb6d9b/33/0", setData, level, data, total_time, cfg_valid);
        end
        state = 3'd0;
        cyc(2);
        rst_n = 1'b1;
        cyc(HOLD + SETTLE);
        key_level = 1'b0;
        cyc(SETTLE);
        state = 3'd2;
        cyc(4);
        checks++; if (level !== 3'd3 || setData !== 3'd0) begin errors++; $display("FAIL held_key_after_reset got=%0d/%0d exp=3/0", level, setData); end
    endtask

`ifdef WASH_DEBOUNCE_EN
    task automatic test_debounce();
        key_mode = 1'b1; cyc(5);
        key_mode = 1'b0; cyc(20);
        checks++; if (setData !== 3'd0) begin errors++; $display("FAIL deb_glitch got=%0d exp=0", setData); end
        key_mode = 1'b1; cyc(10);
        key_mode = 1'b0; cyc(20);
        checks++; if (setData !== 3'd1) begin errors++; $display("FAIL deb_press got=%0d exp=1", setData); end
    endtask
`endif

    initial begin
        test_reset();
        test_mode();
        test_level();
        test_ok();
        test_back_to_idle();
        test_reset_mid_edit();
`ifdef WASH_DEBOUNCE_EN
        test_debounce();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
